id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard detection built in.
- Latches decoded instruction fields and control each cycle. Its registered RS_ID/RT_ID and wr_EX/RD_EX feed the Forwarding_unit and the EX operand muxes.
- Detects a load in EX followed by a dependent instruction in decode. It stalls IF/ID and inserts a bubble into EX.
- Also provides flush (taken branch/jump) and a global hold, plus a saturating stall performance counter.

Parameters:
- DW, 32, register/immediate data width
- CW, 16, stall counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  global freeze (memory busy); all state held
- flush  input  1  squash instruction entering EX (branch taken)
- cnt_clr  input  1  synchronous clear of stall counter
- valid_dec  input  1  decode slot holds a real instruction
- RS_dec, RT_dec, RD_dec  input  5 each  source/dest specifiers from decode (RD_dec already RegDst-selected)
- uses_rt_dec  input  1  instruction reads RT as a source
- rs_data_dec, rt_data_dec, imm_dec  input  DW each  register-file reads, sign-extended immediate
- wr_dec, mem_rd_dec, mem_wr_dec, alu_src_dec  input  1 each  control bits
- alu_op_dec  input  4  ALU operation
- stall_IF  output  1  hold PC and IF/ID register (combinational)
- valid_EX  output  1  registered valid
- RS_ID, RT_ID, RD_EX  output  5 each  registered specifiers
- rs_data_EX, rt_data_EX, imm_EX  output  DW each  registered data
- wr_EX, mem_rd_EX, mem_wr_EX, alu_src_EX  output  1 each  registered control
- alu_op_EX  output  4  registered ALU op
- stall_cnt  output  CW  load-use stall cycles counted

Behaviour:
- Reset (rst_n=0, async): every registered output is 0; stall_cnt=0. stall_IF is 0 while in reset. Release is synchronous to the next rising edge.
- Hazard term, combinational:
  - lu = valid_EX & mem_rd_EX & (RD_EX!=0) & valid_dec & (RD_EX==RS_dec | (uses_rt_dec & RD_EX==RT_dec)).
  - stall_IF = lu & ~flush.
  - A flush kills the dependent instruction, so no stall is needed.
- Per rising edge, priority from highest to lowest:
  - hold=1: all registers and stall_cnt keep their value. stall_IF is still driven from lu.
  - flush=1: bubble.
  - lu=1: bubble.
  - otherwise: load. Every *_EX/ID output takes its *_dec input; valid_EX=valid_dec.
- Bubble definition: valid_EX, wr_EX, mem_rd_EX, mem_wr_EX, alu_src_EX, alu_op_EX, RS_ID, RT_ID, RD_EX, rs_data_EX, rt_data_EX, imm_EX all become 0. A zero RD/RS/RT never produces a forwarding match.
- Latency: one cycle from decode to EX outputs. A load-use pair costs exactly one bubble. On the next cycle the load is in MEM, lu deasserts, and the dependent instruction loads.
- Stall counter, evaluated only when hold=0:
  - cnt_clr=1 sets the counter to 0; clear has priority over increment.
  - Otherwise it increments when stall_IF=1.
  - Saturates at all-ones (0xFFFF) with no wrap.
- Boundaries:
  - Load with RD=0 (or a non-load writer) never stalls.
  - Back-to-back loads to the same register: each dependent instruction stalls once.
  - hold and lu together: no bubble is inserted and the counter does not increment. Stall persists after hold drops.
  - Async reset mid-stall: outputs clear immediately.

Test Plan:
- Reset: rst_n=0 with random inputs -> all outputs 0, stall_cnt=0. After release, one edge with valid_dec=1, RS_dec=3, rs_data_dec=0x1234 -> RS_ID=3, rs_data_EX=0x1234, valid_EX=1.
- Load-use on RS: EX holds lw RD_EX=8; decode RS_dec=8 -> stall_IF=1. Next edge: bubble (valid_EX=0, wr_EX=0, RD_EX=0), stall_cnt=1. Next edge: dependent instruction loads with RS_ID=8.
- RT sensitivity: EX lw RD_EX=9; decode RT_dec=9. With uses_rt_dec=0 -> stall_IF=0, normal load. With uses_rt_dec=1 -> stall_IF=1.
- Flush priority: lu condition true and flush=1 -> stall_IF=0, bubble inserted, stall_cnt unchanged.
- Hold: hold=1 for 3 cycles with changing decode inputs -> outputs and stall_cnt frozen. After hold=0, normal operation resumes.
- Counter saturation: force 0xFFFE stalls, then 2 more -> stall_cnt=0xFFFF. cnt_clr=1 together with a stall -> 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Includes load-use hazard detection, flush/hold control and a saturating stall counter.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          cnt_clr,
    input  logic          valid_dec,
    input  logic [4:0]    RS_dec,
    input  logic [4:0]    RT_dec,
    input  logic [4:0]    RD_dec,
    input  logic          uses_rt_dec,
    input  logic [DW-1:0] rs_data_dec,
    input  logic [DW-1:0] rt_data_dec,
    input  logic [DW-1:0] imm_dec,
    input  logic          wr_dec,
    input  logic          mem_rd_dec,
    input  logic          mem_wr_dec,
    input  logic          alu_src_dec,
    input  logic [3:0]    alu_op_dec,
    output logic          stall_IF,
    output logic          valid_EX,
    output logic [4:0]    RS_ID,
    output logic [4:0]    RT_ID,
    output logic [4:0]    RD_EX,
    output logic [DW-1:0] rs_data_EX,
    output logic [DW-1:0] rt_data_EX,
    output logic [DW-1:0] imm_EX,
    output logic          wr_EX,
    output logic          mem_rd_EX,
    output logic          mem_wr_EX,
    output logic          alu_src_EX,
    output logic [3:0]    alu_op_EX,
    output logic [CW-1:0] stall_cnt
);

    typedef struct packed {
        logic          valid;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic          wr;
        logic          mem_rd;
        logic          mem_wr;
        logic          alu_src;
        logic [3:0]    alu_op;
    } stage_t;

    stage_t        ex_q, ex_d, dec;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_hit, rt_hit, lu, bubble;

    always_comb begin
        dec         = '0;
        dec.valid   = valid_dec;
        dec.rs      = RS_dec;
        dec.rt      = RT_dec;
        dec.rd      = RD_dec;
        dec.rs_data = rs_data_dec;
        dec.rt_data = rt_data_dec;
        dec.imm     = imm_dec;
        dec.wr      = wr_dec;
        dec.mem_rd  = mem_rd_dec;
        dec.mem_wr  = mem_wr_dec;
        dec.alu_src = alu_src_dec;
        dec.alu_op  = alu_op_dec;
    end

    // Load in EX whose destination is read by the instruction now in decode.
    always_comb begin
        rs_hit   = (ex_q.rd == RS_dec);
        rt_hit   = uses_rt_dec & (ex_q.rd == RT_dec);
        lu       = ex_q.valid & ex_q.mem_rd & (ex_q.rd != 5'd0) & valid_dec & (rs_hit | rt_hit);
        stall_IF = lu & ~flush;
        bubble   = flush | lu;
    end

    always_comb begin
        ex_d = ex_q;
        if (!hold) begin
            if (bubble) begin
                ex_d = '0;
            end else begin
                ex_d = dec;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!hold) begin
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (stall_IF && (cnt_q != {CW{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_EX   = ex_q.valid;
    assign RS_ID      = ex_q.rs;
    assign RT_ID      = ex_q.rt;
    assign RD_EX      = ex_q.rd;
    assign rs_data_EX = ex_q.rs_data;
    assign rt_data_EX = ex_q.rt_data;
    assign imm_EX     = ex_q.imm;
    assign wr_EX      = ex_q.wr;
    assign mem_rd_EX  = ex_q.mem_rd;
    assign mem_wr_EX  = ex_q.mem_wr;
    assign alu_src_EX = ex_q.alu_src;
    assign alu_op_EX  = ex_q.alu_op;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, corner sequences and
// randomized traffic against a behavioural model of the EX register and stall counter.
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int SCW = 4;

    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd;
        bit        uses_rt;
        bit [31:0] rs_data, rt_data, imm;
        bit        wr, mem_rd, mem_wr, alu_src;
        bit [3:0]  alu_op;
    } dec_t;

    typedef struct {
        dec_t     d;
        bit       hold, flush, clr;
        bit       exp_stall, exp_valid;
        bit [4:0] exp_rd, exp_rs;
        int       exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic hold, flush, cnt_clr, valid_dec, uses_rt_dec;
    logic [4:0] RS_dec, RT_dec, RD_dec;
    logic [DW-1:0] rs_data_dec, rt_data_dec, imm_dec;
    logic wr_dec, mem_rd_dec, mem_wr_dec, alu_src_dec;
    logic [3:0] alu_op_dec;

    logic stall_IF, valid_EX, wr_EX, mem_rd_EX, mem_wr_EX, alu_src_EX;
    logic [4:0] RS_ID, RT_ID, RD_EX;
    logic [DW-1:0] rs_data_EX, rt_data_EX, imm_EX;
    logic [3:0] alu_op_EX;
    logic [CW-1:0] stall_cnt;

    logic s_stall_IF, s_valid_EX, s_wr_EX, s_mem_rd_EX, s_mem_wr_EX, s_alu_src_EX;
    logic [4:0] s_RS_ID, s_RT_ID, s_RD_EX;
    logic [DW-1:0] s_rs_data_EX, s_rt_data_EX, s_imm_EX;
    logic [3:0] s_alu_op_EX;
    logic [SCW-1:0] s_stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
        .valid_dec(valid_dec), .RS_dec(RS_dec), .RT_dec(RT_dec), .RD_dec(RD_dec),
        .uses_rt_dec(uses_rt_dec), .rs_data_dec(rs_data_dec), .rt_data_dec(rt_data_dec),
        .imm_dec(imm_dec), .wr_dec(wr_dec), .mem_rd_dec(mem_rd_dec), .mem_wr_dec(mem_wr_dec),
        .alu_src_dec(alu_src_dec), .alu_op_dec(alu_op_dec), .stall_IF(stall_IF),
        .valid_EX(valid_EX), .RS_ID(RS_ID), .RT_ID(RT_ID), .RD_EX(RD_EX),
        .rs_data_EX(rs_data_EX), .rt_data_EX(rt_data_EX), .imm_EX(imm_EX), .wr_EX(wr_EX),
        .mem_rd_EX(mem_rd_EX), .mem_wr_EX(mem_wr_EX), .alu_src_EX(alu_src_EX),
        .alu_op_EX(alu_op_EX), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    id_ex_stage #(.DW(DW), .CW(SCW)) dut_s (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
        .valid_dec(valid_dec), .RS_dec(RS_dec), .RT_dec(RT_dec), .RD_dec(RD_dec),
        .uses_rt_dec(uses_rt_dec), .rs_data_dec(rs_data_dec), .rt_data_dec(rt_data_dec),
        .imm_dec(imm_dec), .wr_dec(wr_dec), .mem_rd_dec(mem_rd_dec), .mem_wr_dec(mem_wr_dec),
        .alu_src_dec(alu_src_dec), .alu_op_dec(alu_op_dec), .stall_IF(s_stall_IF),
        .valid_EX(s_valid_EX), .RS_ID(s_RS_ID), .RT_ID(s_RT_ID), .RD_EX(s_RD_EX),
        .rs_data_EX(s_rs_data_EX), .rt_data_EX(s_rt_data_EX), .imm_EX(s_imm_EX),
        .wr_EX(s_wr_EX), .mem_rd_EX(s_mem_rd_EX), .mem_wr_EX(s_mem_wr_EX),
        .alu_src_EX(s_alu_src_EX), .alu_op_EX(s_alu_op_EX), .stall_cnt(s_stall_cnt)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    dec_t m;            // instruction currently modelled in EX (all-zero = bubble)
    int   m_cnt, ms_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit urt,
                                bit wr, bit mrd);
        dec_t d;
        d.valid = v; d.rs = rs; d.rt = rt; d.rd = rd; d.uses_rt = urt;
        d.rs_data = {16'hA5A5, 11'd0, rs};
        d.rt_data = {16'h5A5A, 11'd0, rt};
        d.imm = {16'h0F0F, 11'd0, rd};
        d.wr = wr; d.mem_rd = mrd; d.mem_wr = 1'b0; d.alu_src = mrd;
        d.alu_op = rd[3:0];
        return d;
    endfunction

    function automatic dec_t rnd_dec();
        dec_t d;
        d.valid = ($urandom_range(0, 7) != 0);
        d.rs = 5'($urandom_range(0, 3));
        d.rt = 5'($urandom_range(0, 3));
        d.rd = 5'($urandom_range(0, 3));
        d.uses_rt = 1'($urandom);
        d.rs_data = $urandom; d.rt_data = $urandom; d.imm = $urandom;
        d.wr = 1'($urandom); d.mem_rd = 1'($urandom); d.mem_wr = 1'($urandom);
        d.alu_src = 1'($urandom); d.alu_op = 4'($urandom);
        return d;
    endfunction

    function automatic bit model_lu(dec_t d);
        return m.valid && m.mem_rd && (m.rd != 0) && d.valid &&
               ((m.rd == d.rs) || (d.uses_rt && (m.rd == d.rt)));
    endfunction

    task automatic drive(input dec_t d, input bit h, input bit f, input bit c);
        valid_dec = d.valid; RS_dec = d.rs; RT_dec = d.rt; RD_dec = d.rd;
        uses_rt_dec = d.uses_rt; rs_data_dec = d.rs_data; rt_data_dec = d.rt_data;
        imm_dec = d.imm; wr_dec = d.wr; mem_rd_dec = d.mem_rd; mem_wr_dec = d.mem_wr;
        alu_src_dec = d.alu_src; alu_op_dec = d.alu_op;
        hold = h; flush = f; cnt_clr = c;
    endtask

    task automatic model_reset();
        m = mk(0, 0, 0, 0, 0, 0, 0);
        m.rs_data = 0; m.rt_data = 0; m.imm = 0; m.alu_op = 0; m.alu_src = 0;
        m_cnt = 0; ms_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid_EX"}, valid_EX, m.valid);
        check({tag, ".RS_ID"}, RS_ID, m.rs);
        check({tag, ".RT_ID"}, RT_ID, m.rt);
        check({tag, ".RD_EX"}, RD_EX, m.rd);
        check({tag, ".rs_data_EX"}, rs_data_EX, m.rs_data);
        check({tag, ".rt_data_EX"}, rt_data_EX, m.rt_data);
        check({tag, ".imm_EX"}, imm_EX, m.imm);
        check({tag, ".ctl"}, {wr_EX, mem_rd_EX, mem_wr_EX, alu_src_EX, alu_op_EX},
              {m.wr, m.mem_rd, m.mem_wr, m.alu_src, m.alu_op});
        check({tag, ".stall_cnt"}, stall_cnt, m_cnt);
        check({tag, ".s_stall_cnt"}, s_stall_cnt, ms_cnt);
    endtask

    // Called one time unit after a rising edge; applies one cycle of stimulus.
    task automatic step(input dec_t d, input bit h, input bit f, input bit c,
                        input string tag);
        bit lu, st;
        drive(d, h, f, c);
        #3;
        lu = model_lu(d);
        st = lu && !f;
        check({tag, ".stall_IF"}, stall_IF, st);
        if (!h) begin
            if (c) begin
                m_cnt = 0; ms_cnt = 0;
            end else if (st) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (ms_cnt < (1 << SCW) - 1) ms_cnt++;
            end
            if (f || lu) m = mk(0, 0, 0, 0, 0, 0, 0);
            else m = d;
            if (f || lu) begin
                m.rs_data = 0; m.rt_data = 0; m.imm = 0; m.alu_op = 0; m.alu_src = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    vec_t vt[$];

    function automatic vec_t vec(dec_t d, bit h, bit f, bit c, bit es, bit ev,
                                 bit [4:0] erd, bit [4:0] ers, int ecnt);
        vec_t v;
        v.d = d; v.hold = h; v.flush = f; v.clr = c;
        v.exp_stall = es; v.exp_valid = ev; v.exp_rd = erd; v.exp_rs = ers; v.exp_cnt = ecnt;
        return v;
    endfunction

    initial begin
        dec_t lw8, lw9, d0;
        lw8 = mk(1, 1, 0, 8, 0, 1, 1);
        lw9 = mk(1, 2, 0, 9, 0, 1, 1);
        d0 = mk(0, 0, 0, 0, 0, 0, 0);

        // Reset with random inputs.
        rst_n = 1'b0;
        model_reset();
        drive(rnd_dec(), 1'b0, 1'b0, 1'b0);
        #2;
        check("reset.stall_IF", stall_IF, 1'b0);
        check_outputs("reset");
        @(posedge clk);
        #1;
        check_outputs("reset_edge");
        drive(d0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        d0 = mk(0, 0, 0, 0, 0, 0, 0);
        d0.valid = 1; d0.rs = 3; d0.rs_data = 32'h1234;
        step(d0, 0, 0, 0, "first");
        check("first.RS_ID", RS_ID, 5'd3);
        check("first.rs_data_EX", rs_data_EX, 32'h1234);
        check("first.valid_EX", valid_EX, 1'b1);

        // Directed vectors: {dec, hold, flush, clr, stall, valid, rd, rs, cnt}.
        vt.push_back(vec(lw8, 0, 0, 0, 0, 1, 8, 1, 0));
        vt.push_back(vec(mk(1, 8, 0, 10, 0, 1, 0), 0, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(vec(mk(1, 8, 0, 10, 0, 1, 0), 0, 0, 0, 0, 1, 10, 8, 1));
        vt.push_back(vec(lw9, 0, 0, 0, 0, 1, 9, 2, 1));
        vt.push_back(vec(mk(1, 4, 9, 11, 0, 1, 0), 0, 0, 0, 0, 1, 11, 4, 1));
        vt.push_back(vec(lw9, 0, 0, 0, 0, 1, 9, 2, 1));
        vt.push_back(vec(mk(1, 4, 9, 12, 1, 1, 0), 0, 0, 0, 1, 0, 0, 0, 2));
        vt.push_back(vec(mk(1, 4, 9, 12, 1, 1, 0), 0, 0, 0, 0, 1, 12, 4, 2));
        vt.push_back(vec(mk(1, 0, 0, 5, 0, 1, 1), 0, 0, 0, 0, 1, 5, 0, 2));
        vt.push_back(vec(mk(1, 5, 0, 6, 0, 1, 0), 0, 1, 0, 0, 0, 0, 0, 2));
        vt.push_back(vec(mk(1, 1, 0, 0, 0, 1, 1), 0, 0, 0, 0, 1, 0, 1, 2));
        vt.push_back(vec(mk(1, 0, 0, 7, 0, 1, 0), 0, 0, 0, 0, 1, 7, 0, 2));
        vt.push_back(vec(lw8, 0, 0, 0, 0, 1, 8, 1, 2));
        vt.push_back(vec(mk(1, 8, 0, 3, 0, 1, 0), 1, 0, 0, 1, 1, 8, 1, 2));
        vt.push_back(vec(mk(1, 8, 0, 13, 0, 1, 0), 1, 0, 0, 1, 1, 8, 1, 2));
        vt.push_back(vec(mk(1, 8, 0, 3, 0, 1, 0), 0, 0, 0, 1, 0, 0, 0, 3));
        vt.push_back(vec(mk(1, 8, 0, 3, 0, 1, 0), 0, 0, 0, 0, 1, 3, 8, 3));
        vt.push_back(vec(lw8, 0, 0, 0, 0, 1, 8, 1, 3));
        vt.push_back(vec(mk(1, 8, 0, 3, 0, 1, 0), 0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(vec(lw8, 0, 0, 0, 0, 1, 8, 1, 0));
        vt.push_back(vec(mk(1, 8, 0, 8, 0, 1, 1), 0, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(vec(mk(1, 8, 0, 8, 0, 1, 1), 0, 0, 0, 0, 1, 8, 8, 1));
        vt.push_back(vec(mk(1, 8, 0, 4, 0, 1, 0), 0, 0, 0, 1, 0, 0, 0, 2));
        vt.push_back(vec(mk(1, 8, 0, 4, 0, 1, 0), 0, 0, 0, 0, 1, 4, 8, 2));

        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vt[i].d, vt[i].hold, vt[i].flush, vt[i].clr);
            #3;
            check({tag, ".tbl_stall"}, stall_IF, vt[i].exp_stall);
            #(-3 + 3);
            @(posedge clk);
            #1;
            check({tag, ".tbl_valid"}, valid_EX, vt[i].exp_valid);
            check({tag, ".tbl_rd"}, RD_EX, vt[i].exp_rd);
            check({tag, ".tbl_rs"}, RS_ID, vt[i].exp_rs);
            check({tag, ".tbl_cnt"}, stall_cnt, vt[i].exp_cnt);
        end

        // Resync the model with the state the table left behind.
        m = mk(1, 8, 0, 4, 0, 1, 0);
        m_cnt = 2; ms_cnt = 2;
        check_outputs("post_table");

        // Saturation of the narrow counter, then clear racing a stall.
        for (int i = 0; i < 16; i++) begin
            step(lw8, 0, 0, 0, "sat_lw");
            step(mk(1, 8, 0, 3, 0, 1, 0), 0, 0, 0, "sat_dep");
        end
        check("sat.s_stall_cnt", s_stall_cnt, 4'hF);
        check("sat.stall_cnt", stall_cnt, 16'd18);
        step(lw8, 0, 0, 0, "clr_lw");
        step(mk(1, 8, 0, 3, 0, 1, 0), 0, 0, 1, "clr_dep");
        check("clr.stall_cnt", stall_cnt, 16'd0);
        check("clr.s_stall_cnt", s_stall_cnt, 4'd0);

        // Async reset while a stall is being signalled.
        step(lw8, 0, 0, 0, "ar_lw");
        drive(mk(1, 8, 0, 3, 0, 1, 0), 1'b0, 1'b0, 1'b0);
        #3;
        check("ar.stall_before", stall_IF, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ar.stall_IF", stall_IF, 1'b0);
        check_outputs("ar");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(rnd_dec(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 31) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
